// File: rtl/ctrl_pipe_decoder.sv
// Pipelined RV32I control unit: decodes ID fields into an E-stage control bundle,
// carries the M and W fields through configurable-depth pipes, bubbles load-use
// hazards and drains the pipe after ECALL before raising halt.
module ctrl_pipe_decoder #(
  parameter int unsigned M_DEPTH = 1,
  parameter int unsigned W_DEPTH = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       stall,
  input  logic       flush,
  input  logic       eflush,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic [2:0] imm_mode,
  output logic       load_use,
  output logic [2:0] branch_e,
  output logic [1:0] jump_e,
  output logic [2:0] alu_op_e,
  output logic       alu_alt_e,
  output logic       alu_src_b_e,
  output logic [1:0] alu_src_a_e,
  output logic       uors_e,
  output logic       mem_read_e,
  output logic       mem_write_m,
  output logic       mem_to_reg_m,
  output logic [2:0] ld_mode_m,
  output logic [2:0] st_mode_m,
  output logic       reg_write_w,
  output logic [4:0] rd_w,
  output logic       halt
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  // Counter must hold M_DEPTH+W_DEPTH-1.
  localparam int unsigned CntW = (M_DEPTH + W_DEPTH > 2) ? $clog2(M_DEPTH + W_DEPTH) : 1;
  localparam logic [CntW-1:0] DrainLoad = CntW'(M_DEPTH + W_DEPTH - 1);

  typedef struct packed {
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] ld_mode;
    logic [2:0] st_mode;
    logic       reg_write;
    logic [4:0] rd;
  } m_ctl_t;

  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd;
  } w_ctl_t;

  typedef struct packed {
    logic [2:0] branch;
    logic [1:0] jump;
    logic [2:0] alu_op;
    logic       alu_alt;
    logic       alu_src_b;
    logic [1:0] alu_src_a;
    logic       uors;
    logic       mem_read;
    logic       ecall;
    m_ctl_t     m;
  } e_ctl_t;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  e_ctl_t          w_dec;
  logic            w_uses_rs2;
  logic            w_load_use;
  logic            w_hold_bubble;
  e_ctl_t          r_e;
  m_ctl_t          r_m [M_DEPTH];
  w_ctl_t          r_w [W_DEPTH];
  w_ctl_t          w_m_last;
  state_e          r_state, w_state;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic            r_halt;

  // Decode ID fields into the E bundle, immediate format and rs2 usage.
  always_comb begin
    w_dec      = '0;
    imm_mode   = 3'd0;
    w_uses_rs2 = 1'b1;
    case (opcode)
      OpcOp: begin
        w_dec.alu_op      = funct3;
        w_dec.alu_alt     = funct7_5;
        w_dec.m.reg_write = 1'b1;
      end
      OpcImm: begin
        w_dec.alu_op      = funct3;
        w_dec.alu_alt     = (funct3 == 3'b101) & funct7_5;
        w_dec.alu_src_b   = 1'b1;
        w_dec.m.reg_write = 1'b1;
        imm_mode          = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'd2 : 3'd1;
        w_uses_rs2        = 1'b0;
      end
      OpcLui, OpcAuipc: begin
        w_dec.alu_src_a   = (opcode == OpcLui) ? 2'd2 : 2'd1;
        w_dec.alu_src_b   = 1'b1;
        w_dec.m.reg_write = 1'b1;
        imm_mode          = 3'd3;
        w_uses_rs2        = 1'b0;
      end
      OpcJal: begin
        w_dec.jump        = 2'b01;
        w_dec.m.reg_write = 1'b1;
        imm_mode          = 3'd4;
        w_uses_rs2        = 1'b0;
      end
      OpcJalr: begin
        w_dec.jump        = 2'b10;
        w_dec.alu_src_b   = 1'b1;
        w_dec.m.reg_write = 1'b1;
        imm_mode          = 3'd1;
        w_uses_rs2        = 1'b0;
      end
      OpcBranch: begin
        // Unsigned variants (BLTU/BGEU) compare with the unsigned ALU op.
        w_dec.uors   = funct3[2] & funct3[1];
        w_dec.alu_op = (funct3[2] & funct3[1]) ? 3'b011 : 3'b010;
        imm_mode     = 3'd5;
        case (funct3)
          3'b000:         w_dec.branch = 3'b010;
          3'b001:         w_dec.branch = 3'b101;
          3'b100, 3'b110: w_dec.branch = 3'b100;
          3'b101, 3'b111: w_dec.branch = 3'b011;
          default:        w_dec.branch = 3'b000;
        endcase
      end
      OpcLoad: begin
        w_dec.mem_read     = 1'b1;
        w_dec.alu_src_b    = 1'b1;
        w_dec.m.mem_to_reg = 1'b1;
        w_dec.m.reg_write  = 1'b1;
        imm_mode           = 3'd1;
        w_uses_rs2         = 1'b0;
        case (funct3)
          3'b000:  w_dec.m.ld_mode = 3'b001;
          3'b001:  w_dec.m.ld_mode = 3'b011;
          3'b100:  w_dec.m.ld_mode = 3'b010;
          3'b101:  w_dec.m.ld_mode = 3'b100;
          default: w_dec.m.ld_mode = 3'b000;
        endcase
      end
      OpcStore: begin
        w_dec.alu_src_b   = 1'b1;
        w_dec.m.mem_write = 1'b1;
        imm_mode          = 3'd6;
        case (funct3)
          3'b000:  w_dec.m.st_mode = 3'b010;
          3'b001:  w_dec.m.st_mode = 3'b100;
          default: w_dec.m.st_mode = 3'b000;
        endcase
      end
      OpcSystem: begin
        w_dec.ecall = 1'b1;
        imm_mode    = 3'd1;
        w_uses_rs2  = 1'b0;
      end
      default: ;
    endcase
    // rd only travels with instructions that write back.
    w_dec.m.rd = w_dec.m.reg_write ? rd : 5'd0;
  end

  assign w_load_use = r_e.mem_read & (r_e.m.rd != 5'd0) &
                      ((r_e.m.rd == rs1) | (w_uses_rs2 & (r_e.m.rd == rs2)));
  assign load_use   = w_load_use;

  // Nothing new may follow an ECALL once it reaches E.
  assign w_hold_bubble = w_load_use | (r_state != StRun) | r_e.ecall;

  // E register: hold on stall, bubble on redirect/hazard/halt, else decode.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_e <= '0;
    end else if (!stall) begin
      if (flush || eflush || w_hold_bubble) begin
        r_e <= '0;
      end else begin
        r_e <= w_dec;
      end
    end
  end

  // First M stage takes the E bundle; flush kills the instruction leaving E.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_m[0] <= '0;
    end else if (!stall) begin
      r_m[0] <= flush ? '0 : r_e.m;
    end
  end

  for (genvar g = 1; g < M_DEPTH; g++) begin : g_m_pipe
    // Later M stages shift unconditionally unless stalled.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_m[g] <= '0;
      end else if (!stall) begin
        r_m[g] <= r_m[g-1];
      end
    end
  end

  assign w_m_last = '{reg_write: r_m[M_DEPTH-1].reg_write, rd: r_m[M_DEPTH-1].rd};

  // First W stage takes the write-back fields leaving M.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_w[0] <= '0;
    end else if (!stall) begin
      r_w[0] <= w_m_last;
    end
  end

  for (genvar g = 1; g < W_DEPTH; g++) begin : g_w_pipe
    // Later W stages shift unless stalled.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_w[g] <= '0;
      end else if (!stall) begin
        r_w[g] <= r_w[g-1];
      end
    end
  end

  // Halt FSM next state: count down the in-flight stages behind ECALL.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    case (r_state)
      StRun: begin
        if (r_e.ecall && !stall) begin
          w_state = StDrain;
          w_cnt   = DrainLoad;
        end
      end
      StDrain: begin
        if (!stall) begin
          if (r_cnt == '0) begin
            w_state = StHalted;
          end else begin
            w_cnt = r_cnt - 1'b1;
          end
        end
      end
      StHalted: ;
      default: w_state = StRun;
    endcase
  end

  // Halt FSM state, drain counter and registered halt flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StRun;
      r_cnt   <= '0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_halt  <= (w_state == StHalted);
    end
  end

  assign branch_e     = r_e.branch;
  assign jump_e       = r_e.jump;
  assign alu_op_e     = r_e.alu_op;
  assign alu_alt_e    = r_e.alu_alt;
  assign alu_src_b_e  = r_e.alu_src_b;
  assign alu_src_a_e  = r_e.alu_src_a;
  assign uors_e       = r_e.uors;
  assign mem_read_e   = r_e.mem_read;
  assign mem_write_m  = r_m[M_DEPTH-1].mem_write;
  assign mem_to_reg_m = r_m[M_DEPTH-1].mem_to_reg;
  assign ld_mode_m    = r_m[M_DEPTH-1].ld_mode;
  assign st_mode_m    = r_m[M_DEPTH-1].st_mode;
  assign reg_write_w  = r_w[W_DEPTH-1].reg_write;
  assign rd_w         = r_w[W_DEPTH-1].reg_write ? r_w[W_DEPTH-1].rd : 5'd0;
  assign halt         = r_halt;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: directed program fragments and random traffic,
// every cycle compared against a slot-array model of the control pipeline.
module tb_ctrl_pipe_decoder;

  localparam int unsigned MD = 2;
  localparam int unsigned WD = 1;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic clk = 1'b0;
  logic rstn, stall, flush, eflush;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7_5;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] imm_mode, branch_e, alu_op_e, ld_mode_m, st_mode_m;
  logic [1:0] jump_e, alu_src_a_e;
  logic load_use, alu_alt_e, alu_src_b_e, uors_e, mem_read_e;
  logic mem_write_m, mem_to_reg_m, reg_write_w, halt;
  logic [4:0] rd_w;

  always #5 clk = ~clk;

  ctrl_pipe_decoder #(.M_DEPTH(MD), .W_DEPTH(WD)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .eflush(eflush),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm_mode(imm_mode), .load_use(load_use), .branch_e(branch_e), .jump_e(jump_e),
    .alu_op_e(alu_op_e), .alu_alt_e(alu_alt_e), .alu_src_b_e(alu_src_b_e),
    .alu_src_a_e(alu_src_a_e), .uors_e(uors_e), .mem_read_e(mem_read_e),
    .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m), .ld_mode_m(ld_mode_m),
    .st_mode_m(st_mode_m), .reg_write_w(reg_write_w), .rd_w(rd_w), .halt(halt)
  );

  typedef struct packed {
    logic [2:0] br;
    logic [1:0] jmp;
    logic [2:0] aop;
    logic       alt;
    logic       srcb;
    logic [1:0] srca;
    logic       uors;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic [2:0] ld;
    logic [2:0] st;
    logic       rw;
    logic [4:0] rd;
    logic       ecall;
  } ctl_t;

  // Model: one slot for E, MD slots for M, WD slots for W.
  ctl_t me;
  ctl_t mq [MD];
  ctl_t wq [WD];
  int   drain_left;
  bit   halted;
  bit   last_lu;
  int   total, bad;

  function automatic ctl_t model_decode(logic [6:0] op, logic [2:0] f3, logic f7, logic [4:0] r);
    ctl_t c;
    logic [2:0] br_tbl [8];
    logic [2:0] ld_tbl [8];
    logic [2:0] st_tbl [8];
    br_tbl = '{3'd2, 3'd5, 3'd0, 3'd0, 3'd4, 3'd3, 3'd4, 3'd3};
    ld_tbl = '{3'd1, 3'd3, 3'd0, 3'd0, 3'd2, 3'd4, 3'd0, 3'd0};
    st_tbl = '{3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    c = '0;
    case (op)
      OP_R:   begin c.aop = f3; c.alt = f7; c.rw = 1; end
      OP_I:   begin c.aop = f3; c.srcb = 1; c.rw = 1; c.alt = (f3 == 3'd5) ? f7 : 1'b0; end
      OP_LUI: begin c.srca = 2; c.srcb = 1; c.rw = 1; end
      OP_AUI: begin c.srca = 1; c.srcb = 1; c.rw = 1; end
      OP_JAL: begin c.jmp = 1; c.rw = 1; end
      OP_JR:  begin c.jmp = 2; c.srcb = 1; c.rw = 1; end
      OP_BR:  begin
        c.br = br_tbl[f3];
        c.uors = (f3 >= 3'd6);
        c.aop = (f3 >= 3'd6) ? 3'd3 : 3'd2;
      end
      OP_LD:  begin c.mrd = 1; c.m2r = 1; c.rw = 1; c.srcb = 1; c.ld = ld_tbl[f3]; end
      OP_ST:  begin c.mwr = 1; c.srcb = 1; c.st = st_tbl[f3]; end
      OP_SYS: c.ecall = 1;
      default: ;
    endcase
    c.rd = c.rw ? r : 5'd0;
    return c;
  endfunction

  function automatic logic [2:0] model_imm(logic [6:0] op, logic [2:0] f3);
    case (op)
      OP_I:                return (f3 == 3'd1 || f3 == 3'd5) ? 3'd2 : 3'd1;
      OP_LD, OP_JR, OP_SYS: return 3'd1;
      OP_LUI, OP_AUI:      return 3'd3;
      OP_JAL:              return 3'd4;
      OP_BR:               return 3'd5;
      OP_ST:               return 3'd6;
      default:             return 3'd0;
    endcase
  endfunction

  function automatic bit reads_rs2(logic [6:0] op);
    return !(op == OP_I || op == OP_LD || op == OP_JR || op == OP_SYS ||
             op == OP_LUI || op == OP_AUI || op == OP_JAL);
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive ID and controls, compare everything, advance the model.
  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [4:0] r, input logic [4:0] a, input logic [4:0] b,
                      input logic st, input logic fl, input logic ef);
    bit   lu;
    bit   halting;
    opcode = op; funct3 = f3; funct7_5 = f7; rd = r; rs1 = a; rs2 = b;
    stall = st; flush = fl; eflush = ef;
    #1;
    lu = me.mrd && (me.rd != 5'd0) && ((me.rd == a) || (reads_rs2(op) && me.rd == b));
    chk("imm_mode", 8'(imm_mode), 8'(model_imm(op, f3)));
    chk("load_use", 8'(load_use), 8'(lu));
    chk("branch_e", 8'(branch_e), 8'(me.br));
    chk("jump_e", 8'(jump_e), 8'(me.jmp));
    chk("alu_op_e", 8'(alu_op_e), 8'(me.aop));
    chk("alu_alt_e", 8'(alu_alt_e), 8'(me.alt));
    chk("alu_src_b_e", 8'(alu_src_b_e), 8'(me.srcb));
    chk("alu_src_a_e", 8'(alu_src_a_e), 8'(me.srca));
    chk("uors_e", 8'(uors_e), 8'(me.uors));
    chk("mem_read_e", 8'(mem_read_e), 8'(me.mrd));
    chk("mem_write_m", 8'(mem_write_m), 8'(mq[MD-1].mwr));
    chk("mem_to_reg_m", 8'(mem_to_reg_m), 8'(mq[MD-1].m2r));
    chk("ld_mode_m", 8'(ld_mode_m), 8'(mq[MD-1].ld));
    chk("st_mode_m", 8'(st_mode_m), 8'(mq[MD-1].st));
    chk("reg_write_w", 8'(reg_write_w), 8'(wq[WD-1].rw));
    chk("rd_w", 8'(rd_w), 8'(wq[WD-1].rw ? wq[WD-1].rd : 5'd0));
    chk("halt", 8'(halt), 8'(halted));
    last_lu = lu;
    if (!rstn) begin
      me = '0;
      for (int i = 0; i < MD; i++) mq[i] = '0;
      for (int i = 0; i < WD; i++) wq[i] = '0;
      drain_left = -1;
      halted = 0;
    end else if (!st) begin
      halting = (drain_left >= 0) || me.ecall;
      for (int i = WD - 1; i > 0; i--) wq[i] = wq[i-1];
      wq[0] = mq[MD-1];
      for (int i = MD - 1; i > 0; i--) mq[i] = mq[i-1];
      mq[0] = fl ? '0 : me;
      if (drain_left > 0) begin
        drain_left--;
        if (drain_left == 0) halted = 1;
      end else if (drain_left < 0 && me.ecall) begin
        drain_left = MD + WD;
      end
      me = (fl || ef || lu || halting) ? '0 : model_decode(op, f3, f7, r);
    end
    @(negedge clk);
  endtask

  task automatic nop(input logic st, input logic fl);
    step(OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, st, fl, 1'b0);
  endtask

  logic [6:0] q_op;
  logic [2:0] q_f3;
  logic       q_f7, q_st, q_fl, q_ef, p_st;
  logic [4:0] q_rd, q_a, q_b;
  int         n;

  initial begin
    total = 0; bad = 0; drain_left = -1; halted = 0; last_lu = 0; me = '0;
    for (int i = 0; i < MD; i++) mq[i] = '0;
    for (int i = 0; i < WD; i++) wq[i] = '0;
    rstn = 1'b0; stall = 0; flush = 0; eflush = 0;
    opcode = OP_I; funct3 = 0; funct7_5 = 0; rd = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(negedge clk);
    nop(1'b1, 1'b1);  // reset dominates stall and flush
    rstn = 1'b1;
    nop(1'b0, 1'b0);

    // ADD x3,x1,x2 then SRAI x5,x4,3
    step(OP_R, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 0, 0, 0);
    chk("add_alu_op", 8'(alu_op_e), 8'd0);
    chk("add_src_b", 8'(alu_src_b_e), 8'd0);
    step(OP_I, 3'd5, 1'b1, 5'd5, 5'd4, 5'd3, 0, 0, 0);
    chk("srai_alu_op", 8'(alu_op_e), 8'd5);
    chk("srai_alt", 8'(alu_alt_e), 8'd1);
    chk("srai_src_b", 8'(alu_src_b_e), 8'd1);
    nop(0, 0);
    nop(0, 0);
    chk("add_wb_rd", 8'(rd_w), 8'd3);

    // LW x6,0(x1) then dependent ADD x7,x6,x2 held in ID
    step(OP_LD, 3'd2, 1'b0, 5'd6, 5'd1, 5'd0, 0, 0, 0);
    step(OP_R, 3'd0, 1'b0, 5'd7, 5'd6, 5'd2, 0, 0, 0);
    chk("lu_bubble_mem_read", 8'(mem_read_e), 8'd0);
    step(OP_R, 3'd0, 1'b0, 5'd7, 5'd6, 5'd2, 0, 0, 0);
    chk("lw_m_to_reg", 8'(mem_to_reg_m), 8'd1);
    chk("lw_ld_mode", 8'(ld_mode_m), 8'd0);
    nop(0, 0);

    // SW flushed while in E
    step(OP_ST, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    nop(0, 1);
    nop(0, 0);
    chk("flushed_sw", 8'(mem_write_m), 8'd0);

    // older ADD already past M stage 0 survives a flush
    step(OP_R, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2, 0, 0, 0);
    nop(0, 0);
    nop(0, 1);
    nop(0, 0);
    chk("old_add_wb", 8'(reg_write_w), 8'd1);

    // branches
    step(OP_BR, 3'd7, 1'b0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    chk("bgeu_branch", 8'(branch_e), 8'd3);
    chk("bgeu_alu_op", 8'(alu_op_e), 8'd3);
    chk("bgeu_uors", 8'(uors_e), 8'd1);
    step(OP_BR, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    chk("bne_branch", 8'(branch_e), 8'd5);
    chk("bne_uors", 8'(uors_e), 8'd0);

    // stall two cycles with ADD in E
    step(OP_R, 3'd0, 1'b0, 5'd10, 5'd1, 5'd2, 0, 0, 0);
    nop(1, 0);
    nop(1, 1);
    repeat (4) nop(0, 0);

    // random traffic obeying the hold protocol for stall and load_use
    p_st = 0;
    q_op = OP_I; q_f3 = 0; q_f7 = 0; q_rd = 0; q_a = 0; q_b = 0; q_fl = 0; q_ef = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(p_st || last_lu)) begin
        case ($urandom_range(0, 8))
          0: q_op = OP_R;   1: q_op = OP_I;   2: q_op = OP_LUI;
          3: q_op = OP_AUI; 4: q_op = OP_JAL; 5: q_op = OP_JR;
          6: q_op = OP_BR;  7: q_op = OP_LD;  default: q_op = OP_ST;
        endcase
        q_f3 = 3'($urandom_range(0, 7));
        q_f7 = 1'($urandom_range(0, 1));
        q_rd = 5'($urandom_range(0, 7));
        q_a  = 5'($urandom_range(0, 7));
        q_b  = 5'($urandom_range(0, 7));
      end
      if (!p_st) begin
        q_fl = ($urandom_range(0, 9) == 0);
        q_ef = ($urandom_range(0, 11) == 0);
      end
      q_st = ($urandom_range(0, 5) == 0);
      step(q_op, q_f3, q_f7, q_rd, q_a, q_b, q_st, q_fl, q_ef);
      p_st = q_st;
    end
    repeat (4) nop(0, 0);

    // ECALL drain without stall; younger ADDs and a flush during DRAIN
    step(OP_R, 3'd0, 1'b0, 5'd11, 5'd1, 5'd2, 0, 0, 0);
    step(OP_SYS, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    n = 0;
    while (halt !== 1'b1 && n < 20) begin
      step(OP_R, 3'd0, 1'b0, 5'd12, 5'd1, 5'd2, 0, (n == 1), 0);
      n++;
    end
    chk("halt_latency", 8'(n), 8'(MD + WD + 1));
    repeat (3) step(OP_R, 3'd0, 1'b0, 5'd13, 5'd1, 5'd2, 0, 0, 0);
    chk("halted_no_wb", 8'(reg_write_w), 8'd0);
    rstn = 1'b0;
    nop(0, 0);
    rstn = 1'b1;
    chk("halt_cleared", 8'(halt), 8'd0);

    // ECALL drain with one stall cycle
    step(OP_SYS, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    n = 0;
    while (halt !== 1'b1 && n < 20) begin
      step(OP_LD, 3'd2, 1'b0, 5'd14, 5'd1, 5'd0, (n == 1), 0, 0);
      n++;
    end
    chk("halt_latency_stall", 8'(n), 8'(MD + WD + 2));
    rstn = 1'b0;
    step(OP_R, 3'd0, 1'b0, 5'd15, 5'd1, 5'd2, 0, 0, 0);
    rstn = 1'b1;
    repeat (6) step(OP_R, 3'd0, 1'b0, 5'd15, 5'd1, 5'd2, 0, 0, 0);
    chk("post_reset_wb_rd", 8'(rd_w), 8'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_decoder.md
# ctrl_pipe_decoder

Parametrised pipelined control unit for the RV32I core. It decodes the ID-stage instruction fields into a registered control bundle and carries that bundle through configurable-depth MEM and WB control pipes. It adds three things to the current E/M/W control path: global stall, load-use hazard bubbling, and an ECALL halt that waits for the pipeline to drain. It sits between the IF/ID register and the datapath's EX/MEM/WB muxes.

## Interface
- M_DEPTH, 1, number of control register stages from E to M (≥1)
- W_DEPTH, 1, number of control register stages from M to W (≥1)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- stall  in  1  freeze every control register (memory wait)
- flush  in  1  branch/jump redirect: bubble E and the first M-pipe stage
- eflush  in  1  bubble E only
- opcode  in  7  ID instruction [6:0]
- funct3  in  3  ID instruction [14:12]
- funct7_5  in  1  ID instruction bit 30
- rd, rs1, rs2  in  5 each  ID register indices
- imm_mode  out  3  combinational immediate format: R=0, I=1, shamt=2, U=3, J=4, B=5, S=6; unknown opcode=0
- load_use  out  1  combinational hazard flag; IF/ID must hold while it is high
- branch_e  out  3  branch condition: BEQ=010, BNE=101, BLT/BLTU=100, BGE/BGEU=011, none=000
- jump_e  out  2  01=JAL, 10=JALR, 00=none
- alu_op_e  out  3  ALU function
- alu_alt_e  out  1  SUB/SRA select
- alu_src_b_e  out  1  1=immediate, 0=rs2
- alu_src_a_e  out  2  0=rs1, 1=PC, 2=zero
- uors_e  out  1  unsigned compare
- mem_read_e  out  1  load in E
- mem_write_m, mem_to_reg_m  out  1 each  M-stage controls
- ld_mode_m  out  3  LW=000, LB=001, LBU=010, LH=011, LHU=100
- st_mode_m  out  3  SW=000, SB=010, SH=100
- reg_write_w  out  1  WB enable
- rd_w  out  5  WB destination
- halt  out  1  registered; high once ECALL has drained

## Operation
- Reset: every E/M/W output is 0, halt=0, the FSM is in RUN, and the drain counter is 0.
- Update priority for the E register: rstn > stall (hold) > flush or eflush (bubble) > load_use or FSM≠RUN (bubble) > decode.
- Bubble: the all-zero bundle. reg_write=0 and mem_write=0 for any bubble.
- OP (0110011):
  - alu_op=funct3, alu_alt=funct7_5, src_b=0, reg_write=1.
- OP-IMM (0010011):
  - alu_op=funct3, src_b=1, reg_write=1.
  - alu_alt=funct7_5 only when funct3=101 (SRAI); otherwise alu_alt=0.
- LUI: src_a=2, src_b=1, add. AUIPC: src_a=1, src_b=1, add.
- JAL: jump=01. JALR: jump=10, src_b=1. Both set reg_write=1.
- BRANCH (1100011):
  - src_b=0, no write.
  - alu_op=010 (signed); BLTU/BGEU use alu_op=011 and uors=1.
  - funct3 010/011 decode as none.
- LOAD (0000011): mem_read=1, mem_to_reg=1, reg_write=1, src_b=1, add; ld_mode per funct3 (others→000).
- STORE (0100011): mem_write=1, src_b=1, add; st_mode per funct3 (others→000).
- SYSTEM (1110011): ECALL; bubble payload plus an internal ecall_e flag.
- rd_w is forced to 0 whenever reg_write is 0. reg_write for rd=x0 stays 1; the regfile ignores it.
- load_use = mem_read_e & (rd_e≠0) & ((rd_e==rs1) | (rd_e==rs2)). rs2 is ignored for I/U/J-format opcodes.
- Pipes: the M fields shift through M_DEPTH registers and the W fields through W_DEPTH further registers.
  - flush zeroes M-pipe stage 0 only; later stages shift normally, preserving older instructions.
  - stall freezes every stage.
- Halt FSM:
  - RUN → DRAIN when ecall_e=1 and stall=0; load cnt=M_DEPTH+W_DEPTH−1.
  - DRAIN: decrement cnt on each non-stall cycle. At cnt=0 with no stall, go to HALTED.
  - HALTED: halt=1 and the decode bubble is held until rstn.
  - flush and eflush do not affect DRAIN or HALTED.

## Timing
- Instruction in ID at cycle n:
  - E outputs at n+1.
  - M outputs at n+1+M_DEPTH.
  - W outputs at n+1+M_DEPTH+W_DEPTH.
  - Each stalled cycle adds 1 to every latency.
- ECALL on E at cycle t (no stalls): halt=1 from cycle t+M_DEPTH+W_DEPTH+1 (t+3 at defaults). Older instructions finish WB first.
- load_use in cycle n: E at n+1 is a bubble. The dependent instruction, held in ID, decodes at n+2.
- stall together with flush: stall wins; upstream must hold flush.
- rstn low mid-DRAIN or in HALTED: return to RUN and all zeros on the next edge.

## Test plan
- ADD x3,x1,x2 then SRAI x5,x4,3 back to back:
  - ADD at E cycle 1: alu_op=000, alu_alt=0, src_b=0.
  - SRAI at E cycle 2: alu_op=101, alu_alt=1, src_b=1.
  - reg_write_w=1 with rd_w=3 at cycle 3.
- LW x6,0(x1) then ADD x7,x6,x2:
  - load_use=1 for one cycle, then an E bubble.
  - ADD reaches E two cycles after LW.
  - LW at M has ld_mode_m=000 and mem_to_reg_m=1.
- SW followed by flush in the cycle SW sits in E: mem_write_m stays 0.
- Older ADD in M when flush is asserted: its reg_write_w=1 still appears.
- BGEU: branch_e=011, alu_op=011, uors=1. BNE: branch_e=101, uors=0.
- Stall held 2 cycles with ADD in E: all outputs frozen; ADD reaches W 2 cycles later than nominal.
- M_DEPTH=2, W_DEPTH=1, ECALL in E at cycle 10:
  - halt=1 from cycle 14; with 1 stall cycle, from 15.
  - Instructions behind ECALL never assert reg_write_w.
  - rstn low then clears halt.
